// File: rtl/egg_timer_countdown_if.sv
// Control/preset and display bundle between the debounce stage, the countdown core and the display/LED stage.
// Pure wiring: no latency, no backpressure (pulse-driven, level outputs).
interface egg_timer_countdown_if;
  logic       start_in;
  logic       stop_in;
  logic [6:0] min_in;
  logic [5:0] sec_in;
  logic [6:0] min_out;
  logic [5:0] sec_out;
  logic       running_out;
  logic       alarm_out;
  logic       blink_out;

  modport master (
    output start_in, stop_in, min_in, sec_in,
    input  min_out, sec_out, running_out, alarm_out, blink_out
  );

  modport slave (
    input  start_in, stop_in, min_in, sec_in,
    output min_out, sec_out, running_out, alarm_out, blink_out
  );
endinterface

// File: rtl/egg_timer_countdown.sv
// MM:SS countdown with pause/resume/cancel, alarm and blink pulse train at 00:00.
// Latency: all outputs registered, change on the edge that samples start/stop; no backpressure.
module egg_timer_countdown #(
  parameter int TICKS_PER_SEC = 100_000_000,
  parameter int BLINK_DIV     = 25_000_000
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  egg_timer_countdown_if.slave  bus
);

  localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [6:0]      min_q, min_d;
  logic [5:0]      sec_q, sec_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic            blink_q, blink_d;
  logic            running_q, running_d;
  logic            alarm_q, alarm_d;

  logic [6:0]      min_clamp;
  logic [5:0]      sec_clamp;
  logic            sec_tick;
  logic            start_only;

  assign min_clamp  = (bus.min_in > 7'd99) ? 7'd99 : bus.min_in;
  assign sec_clamp  = (bus.sec_in > 6'd59) ? 6'd59 : bus.sec_in;
  assign sec_tick   = (presc_q == PW'(TICKS_PER_SEC - 1));
  // stop has priority over start everywhere
  assign start_only = bus.start_in & ~bus.stop_in;

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sec_d   = sec_q;
    presc_d = presc_q;
    bcnt_d  = '0;
    blink_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_only && (min_clamp != 7'd0 || sec_clamp != 6'd0)) begin
          state_d = S_RUN;
          min_d   = min_clamp;
          sec_d   = sec_clamp;
          presc_d = '0;
        end
      end
      S_RUN: begin
        if (bus.stop_in) begin
          state_d = S_PAUSE;
        end else if (sec_tick) begin
          presc_d = '0;
          if (sec_q != 6'd0) begin
            sec_d = sec_q - 6'd1;
          end else begin
            min_d = min_q - 7'd1;
            sec_d = 6'd59;
          end
          if (min_q == 7'd0 && sec_q == 6'd1) begin
            state_d = S_DONE;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      S_PAUSE: begin
        if (bus.stop_in) begin
          state_d = S_IDLE;
          min_d   = 7'd0;
          sec_d   = 6'd0;
        end else if (bus.start_in) begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (bus.stop_in) begin
          state_d = S_IDLE;
        end else if (bcnt_q == BW'(BLINK_DIV - 1)) begin
          blink_d = 1'b1;
        end else begin
          bcnt_d = bcnt_q + BW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    running_d = (state_d == S_RUN);
    alarm_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= S_IDLE;
      min_q     <= '0;
      sec_q     <= '0;
      presc_q   <= '0;
      bcnt_q    <= '0;
      blink_q   <= 1'b0;
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      presc_q   <= presc_d;
      bcnt_q    <= bcnt_d;
      blink_q   <= blink_d;
      running_q <= running_d;
      alarm_q   <= alarm_d;
    end
  end

  assign bus.min_out     = min_q;
  assign bus.sec_out     = sec_q;
  assign bus.running_out = running_q;
  assign bus.alarm_out   = alarm_q;
  assign bus.blink_out   = blink_q;

endmodule

// File: tb/tb_egg_timer_countdown.sv
// Bench for egg_timer_countdown: directed table, corner sequences and random traffic vs a seconds-based model.
module tb_egg_timer_countdown;
  localparam int TPS = 10;
  localparam int BD  = 4;

  logic clk_in = 1'b0;
  logic rst_n_in;
  always #5 clk_in = ~clk_in;

  egg_timer_countdown_if bus();

  egg_timer_countdown #(.TICKS_PER_SEC(TPS), .BLINK_DIV(BD)) dut (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .bus     (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: remaining time kept as total seconds, cycle counters as plain integers.
  typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE} mode_t;
  mode_t m_mode;
  int    m_rem;
  int    m_elapsed;
  int    m_done_cyc;

  function automatic void model_reset();
    m_mode     = M_IDLE;
    m_rem      = 0;
    m_elapsed  = 0;
    m_done_cyc = 0;
  endfunction

  function automatic void model_step(bit st, bit sp, int mi, int se);
    int lm, ls;
    lm = (mi > 99) ? 99 : mi;
    ls = (se > 59) ? 59 : se;
    case (m_mode)
      M_IDLE: if (st && !sp && (lm * 60 + ls) > 0) begin
        m_rem = lm * 60 + ls; m_elapsed = 0; m_mode = M_RUN;
      end
      M_RUN: if (sp) m_mode = M_PAUSE;
             else if (m_elapsed == TPS - 1) begin
               m_elapsed = 0; m_rem = m_rem - 1;
               if (m_rem == 0) begin m_mode = M_DONE; m_done_cyc = 0; end
             end else m_elapsed = m_elapsed + 1;
      M_PAUSE: if (sp) begin m_mode = M_IDLE; m_rem = 0; end
               else if (st) m_mode = M_RUN;
      M_DONE: if (sp) m_mode = M_IDLE;
              else m_done_cyc = m_done_cyc + 1;
      default: m_mode = M_IDLE;
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cmp_model();
    logic [6:0] em; logic [5:0] es; logic er, ea, eb;
    em = 7'(m_rem / 60);
    es = 6'(m_rem % 60);
    er = (m_mode == M_RUN);
    ea = (m_mode == M_DONE);
    eb = (m_mode == M_DONE) && (m_done_cyc > 0) && (m_done_cyc % BD == 0);
    vectors++;
    if ({bus.min_out, bus.sec_out, bus.running_out, bus.alarm_out, bus.blink_out} !== {em, es, er, ea, eb}) begin
      miscompares++;
      $display("FAIL model t=%0t: got %0d:%0d run=%b alarm=%b blink=%b, expected %0d:%0d run=%b alarm=%b blink=%b",
               $time, bus.min_out, bus.sec_out, bus.running_out, bus.alarm_out, bus.blink_out, em, es, er, ea, eb);
    end
  endtask

  task automatic step(bit st, bit sp);
    bus.start_in = st;
    bus.stop_in  = sp;
    @(posedge clk_in);
    model_step(st, sp, int'(bus.min_in), int'(bus.sec_in));
    #1;
    bus.start_in = 1'b0;
    bus.stop_in  = 1'b0;
    cmp_model();
  endtask

  task automatic preset(int mi, int se);
    bus.min_in = 7'(mi);
    bus.sec_in = 6'(se);
  endtask

  task automatic do_reset();
    rst_n_in = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    check("reset_state", {25'd0, bus.min_out, bus.sec_out, bus.running_out, bus.alarm_out, bus.blink_out}, 32'd0);
    rst_n_in = 1'b1;
  endtask

  typedef struct {
    bit         st, sp;
    int         mi, se;
    logic [6:0] e_min;
    logic [5:0] e_sec;
    logic       e_run, e_alarm;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int n;
    bit found;
    bus.start_in = 1'b0;
    bus.stop_in  = 1'b0;
    preset(0, 0);
    do_reset();

    tbl[0]  = '{1, 0,   2,  5,  2,  5, 1, 0};
    tbl[1]  = '{0, 0,   2,  5,  2,  5, 1, 0};
    tbl[2]  = '{1, 0,   0,  0,  2,  5, 1, 0};
    tbl[3]  = '{0, 1,   0,  0,  2,  5, 0, 0};
    tbl[4]  = '{1, 1,   0,  0,  0,  0, 0, 0};
    tbl[5]  = '{1, 0,   0,  0,  0,  0, 0, 0};
    tbl[6]  = '{1, 0, 120, 63, 99, 59, 1, 0};
    tbl[7]  = '{0, 1,   0,  0, 99, 59, 0, 0};
    tbl[8]  = '{1, 0,   0,  0, 99, 59, 1, 0};
    tbl[9]  = '{0, 1,   0,  0, 99, 59, 0, 0};
    tbl[10] = '{0, 1,   0,  0,  0,  0, 0, 0};
    tbl[11] = '{1, 0,   0, 63,  0, 59, 1, 0};
    tbl[12] = '{0, 1,   0,  0,  0, 59, 0, 0};
    tbl[13] = '{0, 1,   0,  0,  0,  0, 0, 0};
    for (int i = 0; i < 14; i++) begin
      preset(tbl[i].mi, tbl[i].se);
      step(tbl[i].st, tbl[i].sp);
      check($sformatf("tbl%0d_time", i), {19'd0, bus.min_out, bus.sec_out}, {19'd0, tbl[i].e_min, tbl[i].e_sec});
      check($sformatf("tbl%0d_flags", i), {29'd0, bus.running_out, bus.alarm_out, bus.blink_out},
            {29'd0, tbl[i].e_run, tbl[i].e_alarm, 1'b0});
    end

    // 00:03 countdown into DONE, then the blink train and cancel on a pulse edge
    preset(0, 3);
    step(1, 0);
    check("s1_running", 32'(bus.running_out), 32'd1);
    for (int k = 1; k <= 30; k++) begin
      step(0, 0);
      if (k == 10) check("s1_sec_2", 32'(bus.sec_out), 32'd2);
      if (k == 20) check("s1_sec_1", 32'(bus.sec_out), 32'd1);
      if (k == 29) check("s1_no_alarm_yet", 32'(bus.alarm_out), 32'd0);
      if (k == 30) begin
        check("s1_sec_0", 32'(bus.sec_out), 32'd0);
        check("s1_alarm", 32'(bus.alarm_out), 32'd1);
        check("s1_run_off", 32'(bus.running_out), 32'd0);
      end
    end
    for (int k = 1; k <= 11; k++) begin
      step(k == 3, 0);
      check($sformatf("s4_blink_%0d", k), 32'(bus.blink_out), (k % 4 == 0) ? 32'd1 : 32'd0);
    end
    step(0, 1);
    check("s4_stop_alarm", 32'(bus.alarm_out), 32'd0);
    check("s4_stop_blink", 32'(bus.blink_out), 32'd0);
    check("s4_stop_time", {19'd0, bus.min_out, bus.sec_out}, 32'd0);

    // minute borrow
    preset(1, 0);
    step(1, 0);
    repeat (10) step(0, 0);
    check("s2_min", 32'(bus.min_out), 32'd0);
    check("s2_sec", 32'(bus.sec_out), 32'd59);
    step(0, 1);
    step(0, 1);

    // pause holds the partial second; resume completes it
    preset(0, 5);
    step(1, 0);
    repeat (13) step(0, 0);
    step(0, 1);
    check("s3_paused_sec", 32'(bus.sec_out), 32'd4);
    repeat (50) step(0, 0);
    check("s3_frozen_sec", 32'(bus.sec_out), 32'd4);
    check("s3_frozen_run", 32'(bus.running_out), 32'd0);
    step(1, 0);
    n = 0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step(0, 0);
      n++;
      if (bus.sec_out != 6'd4) found = 1'b1;
    end
    check("s3_resume_found", 32'(found), 32'd1);
    check("s3_resume_delay", 32'(n), 32'd7);
    step(0, 1);
    step(0, 1);

    // zero preset ignored; start+stop together in PAUSE cancels
    preset(0, 0);
    step(1, 0);
    check("s5_zero_idle", 32'(bus.running_out), 32'd0);
    preset(0, 5);
    step(1, 0);
    step(0, 1);
    step(1, 1);
    check("s5_both_run", 32'(bus.running_out), 32'd0);
    check("s5_both_time", {19'd0, bus.min_out, bus.sec_out}, 32'd0);

    // asynchronous reset mid-run at 00:07
    preset(0, 9);
    step(1, 0);
    repeat (20) step(0, 0);
    check("s6_at_7", 32'(bus.sec_out), 32'd7);
    #3;
    rst_n_in = 1'b0;
    #1;
    check("s6_async_clear", {25'd0, bus.min_out, bus.sec_out, bus.running_out, bus.alarm_out, bus.blink_out}, 32'd0);
    model_reset();
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    preset(0, 3);
    step(1, 0);
    check("s6_restart", 32'(bus.running_out), 32'd1);
    check("s6_restart_sec", 32'(bus.sec_out), 32'd3);

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      int rm, rs;
      rm = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 1));
      rs = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 4));
      preset(rm, rs);
      step($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
